// File: rtl/ctrl_contador_ajuste.sv
// Wrapping up/down adjustment counter driven by button release ticks, with registered BCD digits.
// Latency: a tick or load in cycle N updates valor, bcd_dec, bcd_uni and cambio together in cycle N+1.
// Backpressure: none; every rising tick edge is acted on in the cycle it arrives.
module ctrl_contador_ajuste #(
    parameter int WIDTH   = 6,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             ticku,
    input  logic             tickd,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] valor,
    output logic [3:0]       bcd_dec,
    output logic [3:0]       bcd_uni,
    output logic             cambio
);

    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [3:0]       MIN_DEC = 4'(MIN_VAL / 10);
    localparam logic [3:0]       MIN_UNI = 4'(MIN_VAL % 10);

    logic             ticku_q;
    logic             tickd_q;
    logic             up_ev;
    logic             dn_ev;
    logic [WIDTH-1:0] load_hi;
    logic [WIDTH-1:0] load_clamp;
    logic [WIDTH-1:0] valor_nxt;
    logic             cambio_nxt;
    logic [6:0]       valor7;
    logic [3:0]       bcd_dec_nxt;
    logic [3:0]       bcd_uni_nxt;

    assign up_ev   = ticku & ~ticku_q;
    assign dn_ev   = tickd & ~tickd_q;
    assign load_hi = (load_val > MAX_W) ? MAX_W : load_val;

    // The low clamp only exists when MIN_VAL is nonzero; an unsigned compare
    // against zero would be constant.
    generate
        if (MIN_VAL > 0) begin : g_min_clamp
            assign load_clamp = (load_val < MIN_W) ? MIN_W : load_hi;
        end else begin : g_no_min_clamp
            assign load_clamp = load_hi;
        end
    endgenerate

    always_comb begin
        valor_nxt  = valor;
        cambio_nxt = 1'b0;
        if (load) begin
            valor_nxt = load_clamp;
        end else if (en && up_ev && !dn_ev) begin
            valor_nxt  = (valor == MAX_W) ? MIN_W : valor + WIDTH'(1);
            cambio_nxt = 1'b1;
        end else if (en && dn_ev && !up_ev) begin
            valor_nxt  = (valor == MIN_W) ? MAX_W : valor - WIDTH'(1);
            cambio_nxt = 1'b1;
        end
    end

    // Digits come from the next value so they are registered alongside valor.
    assign valor7      = 7'(valor_nxt);
    assign bcd_dec_nxt = 4'(valor7 / 7'd10);
    assign bcd_uni_nxt = 4'(valor7 % 7'd10);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ticku_q <= 1'b0;
            tickd_q <= 1'b0;
            valor   <= MIN_W;
            bcd_dec <= MIN_DEC;
            bcd_uni <= MIN_UNI;
            cambio  <= 1'b0;
        end else begin
            ticku_q <= ticku;
            tickd_q <= tickd;
            valor   <= valor_nxt;
            bcd_dec <= bcd_dec_nxt;
            bcd_uni <= bcd_uni_nxt;
            cambio  <= cambio_nxt;
        end
    end

endmodule

// File: tb/tb_ctrl_contador_ajuste.sv
// Directed bench for ctrl_contador_ajuste: default 0..59 instance plus a 1..12 instance.
module tb_ctrl_contador_ajuste;

    logic       clk;
    logic       reset_n;

    logic       en, ticku, tickd, load;
    logic [5:0] load_val;
    logic [5:0] valor;
    logic [3:0] bcd_dec, bcd_uni;
    logic       cambio;

    logic       b_en, b_ticku, b_tickd, b_load;
    logic [3:0] b_load_val;
    logic [3:0] b_valor;
    logic [3:0] b_bcd_dec, b_bcd_uni;
    logic       b_cambio;

    int checks = 0;
    int errors = 0;
    int pulses;

    ctrl_contador_ajuste dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .ticku    (ticku),
        .tickd    (tickd),
        .load     (load),
        .load_val (load_val),
        .valor    (valor),
        .bcd_dec  (bcd_dec),
        .bcd_uni  (bcd_uni),
        .cambio   (cambio)
    );

    ctrl_contador_ajuste #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12)) dut_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (b_en),
        .ticku    (b_ticku),
        .tickd    (b_tickd),
        .load     (b_load),
        .load_val (b_load_val),
        .valor    (b_valor),
        .bcd_dec  (b_bcd_dec),
        .bcd_uni  (b_bcd_uni),
        .cambio   (b_cambio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int v, input int d, input int u, input int c);
        check({tag, ".valor"}, int'(valor), v);
        check({tag, ".dec"}, int'(bcd_dec), d);
        check({tag, ".uni"}, int'(bcd_uni), u);
        check({tag, ".cambio"}, int'(cambio), c);
    endtask

    task automatic chk_b(input string tag, input int v, input int d, input int u, input int c);
        check({tag, ".valor"}, int'(b_valor), v);
        check({tag, ".dec"}, int'(b_bcd_dec), d);
        check({tag, ".uni"}, int'(b_bcd_uni), u);
        check({tag, ".cambio"}, int'(b_cambio), c);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0; ticku = 1'b0; tickd = 1'b0; load = 1'b0; load_val = 6'd0;
        b_en = 1'b0; b_ticku = 1'b0; b_tickd = 1'b0; b_load = 1'b0; b_load_val = 4'd0;
        #12;
        chk_a("rst_a", 0, 0, 0, 0);
        chk_b("rst_b", 1, 0, 1, 0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // T1: asynchronous reset mid-count
        load = 1'b1; load_val = 6'd37;
        cyc();
        load = 1'b0; en = 1'b1;
        chk_a("load37", 37, 3, 7, 0);
        ticku = 1'b1;
        cyc();
        ticku = 1'b0;
        chk_a("up38", 38, 3, 8, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_a("async_rst", 0, 0, 0, 0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // T2: up and wrap from 59 to 0
        load = 1'b1; load_val = 6'd58;
        cyc();
        load = 1'b0;
        ticku = 1'b1;
        cyc();
        ticku = 1'b0;
        chk_a("up59", 59, 5, 9, 1);
        cyc();
        chk_a("up59_hold", 59, 5, 9, 0);
        ticku = 1'b1;
        cyc();
        ticku = 1'b0;
        chk_a("up_wrap", 0, 0, 0, 1);
        cyc();
        chk_a("up_wrap_hold", 0, 0, 0, 0);

        // T3: down wrap, then a held tick counts once
        tickd = 1'b1;
        cyc();
        tickd = 1'b0;
        chk_a("dn_wrap", 59, 5, 9, 1);
        cyc();
        tickd = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (cambio) pulses++;
        end
        tickd = 1'b0;
        check("held_pulses", pulses, 1);
        chk_a("held_dn", 58, 5, 8, 0);
        cyc();

        // T4: simultaneous ticks cancel, disabled ignores ticks
        load = 1'b1; load_val = 6'd20;
        cyc();
        load = 1'b0;
        ticku = 1'b1; tickd = 1'b1;
        cyc();
        ticku = 1'b0; tickd = 1'b0;
        chk_a("both", 20, 2, 0, 0);
        cyc();
        en = 1'b0; ticku = 1'b1;
        cyc();
        ticku = 1'b0;
        chk_a("disabled", 20, 2, 0, 0);
        cyc();
        en = 1'b1; tickd = 1'b1;
        cyc();
        tickd = 1'b0;
        chk_a("dn19", 19, 1, 9, 1);
        cyc();

        // T5: load beats a tick, load saturates above MAX_VAL
        load = 1'b1; load_val = 6'd45; ticku = 1'b1;
        cyc();
        load = 1'b0; ticku = 1'b0;
        chk_a("load45", 45, 4, 5, 0);
        cyc();
        chk_a("load45_hold", 45, 4, 5, 0);
        load = 1'b1; load_val = 6'd63;
        cyc();
        load = 1'b0;
        chk_a("load63", 59, 5, 9, 0);

        // T6: 1..12 instance
        b_en = 1'b1; b_load = 1'b1; b_load_val = 4'd12;
        cyc();
        b_load = 1'b0;
        chk_b("b_load12", 12, 1, 2, 0);
        b_ticku = 1'b1;
        cyc();
        b_ticku = 1'b0;
        chk_b("b_up_wrap", 1, 0, 1, 1);
        cyc();
        b_tickd = 1'b1;
        cyc();
        b_tickd = 1'b0;
        chk_b("b_dn_wrap", 12, 1, 2, 1);
        cyc();
        b_load = 1'b1; b_load_val = 4'd15;
        cyc();
        chk_b("b_load15", 12, 1, 2, 0);
        b_load_val = 4'd0;
        cyc();
        b_load = 1'b0;
        chk_b("b_load0", 1, 0, 1, 0);
        b_load = 1'b1; b_load_val = 4'd7;
        cyc();
        b_load = 1'b0;
        chk_b("b_load7", 7, 0, 7, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_b("b_async_rst", 1, 0, 1, 0);
        chk_a("a_final_rst", 0, 0, 0, 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
